// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Memory-side stage behind the processor datapath. Instruction fetch,
// scalar data accesses and per-lane vector data accesses share one
// single-ported, word-wide memory port and are serialised by one FSM:
//   IDLE -> IFETCH -> DECODE -> [SDATA | VDATA x THREADS] -> DONE
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   iaddr, instReq         fetch address (PC) and fetch enable
//   iload                  latched instruction word (registered)
//   iHit, dHit             one-cycle completion pulses (dHit only when a
//                          data phase took place)
//   readReq, writeReq      data access requested by the decoded iload
//   isVector               latched opcode is vector-class
//   sdaddr/sdstore/sdload  scalar address, store data, load data (registered)
//   vdaddr/vdstore/vdload  per-lane address, store data, load data (registered)
//   dhalt                  processor halted: finish current instruction, park
//   mem_*                  single memory port
//   dbg_state_o/dbg_lane_o FSM state and current vector lane
//
// Memory handshake: mem_ren / mem_wen act as "valid" and !mem_wait as
// "ready". An access completes in the first cycle a strobe is high while
// mem_wait is low. Strobe, address and store data stay constant from the
// first cycle of an access until that completing cycle, and the strobes
// are never both high.
module load_store_unit #(
  parameter  int THREADS = 4,
  parameter  int WORD_W  = 32,
  localparam int LANE_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [WORD_W-1:0]              iaddr,
  input  logic                           instReq,
  output logic [WORD_W-1:0]              iload,
  output logic                           iHit,
  input  logic                           readReq,
  input  logic                           writeReq,
  output logic                           isVector,
  input  logic [WORD_W-1:0]              sdaddr,
  input  logic [WORD_W-1:0]              sdstore,
  output logic [WORD_W-1:0]              sdload,
  input  logic [THREADS-1:0][WORD_W-1:0] vdaddr,
  input  logic [THREADS-1:0][WORD_W-1:0] vdstore,
  output logic [THREADS-1:0][WORD_W-1:0] vdload,
  output logic                           dHit,
  input  logic                           dhalt,
  output logic                           mem_ren,
  output logic                           mem_wen,
  output logic [WORD_W-1:0]              mem_addr,
  output logic [WORD_W-1:0]              mem_store,
  input  logic [WORD_W-1:0]              mem_load,
  input  logic                           mem_wait,
  output logic [2:0]                     dbg_state_o,
  output logic [LANE_W-1:0]              dbg_lane_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DECODE = 3'd2,
    SDATA  = 3'd3,
    VDATA  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(THREADS - 1);

  state_t                           state_q, state_d;
  logic [LANE_W-1:0]                lane_q, lane_d;
  logic [WORD_W-1:0]                iload_q, iload_d;
  logic [WORD_W-1:0]                sdload_q, sdload_d;
  logic [THREADS-1:0][WORD_W-1:0]   vdload_q, vdload_d;
  // Remembers whether this instruction had a data phase, for dHit in DONE.
  logic                             data_q, data_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      iload_q  <= '0;
      sdload_q <= '0;
      vdload_q <= '0;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      iload_q  <= iload_d;
      sdload_q <= sdload_d;
      vdload_q <= vdload_d;
      data_q   <= data_d;
    end
  end

  // The opcode occupies the top six bits of the instruction word; the
  // vector class (VLW/VSW and vector ALU ops) is the upper quarter of the
  // opcode space, i.e. both top opcode bits set.
  assign isVector = (iload_q[WORD_W-1 -: 2] == 2'b11);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    iload_d   = iload_q;
    sdload_d  = sdload_q;
    vdload_d  = vdload_q;
    data_d    = data_q;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_store = '0;

    case (state_q)
      IDLE: begin
        if (instReq && !dhalt) state_d = IFETCH;
      end

      IFETCH: begin
        mem_ren  = 1'b1;
        mem_addr = iaddr;
        if (!mem_wait) begin
          iload_d = mem_load;
          state_d = DECODE;
        end
      end

      DECODE: begin
        data_d = readReq || writeReq;
        if (data_d) state_d = isVector ? VDATA : SDATA;
        else        state_d = DONE;
      end

      SDATA: begin
        mem_addr = sdaddr;
        // A simultaneous read and write request is a read only.
        if (readReq) begin
          mem_ren = 1'b1;
          if (!mem_wait) sdload_d = mem_load;
        end else if (writeReq) begin
          mem_wen   = 1'b1;
          mem_store = sdstore;
        end
        if (!mem_wait) state_d = DONE;
      end

      VDATA: begin
        mem_addr = vdaddr[lane_q];
        if (readReq) begin
          mem_ren = 1'b1;
          if (!mem_wait) vdload_d[lane_q] = mem_load;
        end else if (writeReq) begin
          mem_wen   = 1'b1;
          mem_store = vdstore[lane_q];
        end
        if (!mem_wait) begin
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            state_d = DONE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      DONE: begin
        state_d = (instReq && !dhalt) ? IFETCH : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign iload       = iload_q;
  assign sdload      = sdload_q;
  assign vdload      = vdload_q;
  assign iHit        = (state_q == DONE);
  assign dHit        = (state_q == DONE) && data_q;
  assign dbg_state_o = state_q;
  assign dbg_lane_o  = lane_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios followed by random
// instructions, checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int THREADS = 4;
  localparam int WORD_W  = 32;
  localparam int LANE_W  = 2;
  localparam int REC_W   = 2 + 2 * WORD_W;  // {ren, wen, addr, store}

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [WORD_W-1:0]              iaddr;
  logic                           instReq;
  logic [WORD_W-1:0]              iload;
  logic                           iHit;
  logic                           readReq;
  logic                           writeReq;
  logic                           isVector;
  logic [WORD_W-1:0]              sdaddr;
  logic [WORD_W-1:0]              sdstore;
  logic [WORD_W-1:0]              sdload;
  logic [THREADS-1:0][WORD_W-1:0] vdaddr;
  logic [THREADS-1:0][WORD_W-1:0] vdstore;
  logic [THREADS-1:0][WORD_W-1:0] vdload;
  logic                           dHit;
  logic                           dhalt;
  logic                           mem_ren;
  logic                           mem_wen;
  logic [WORD_W-1:0]              mem_addr;
  logic [WORD_W-1:0]              mem_store;
  logic [WORD_W-1:0]              mem_load;
  logic                           mem_wait;
  logic [2:0]                     dbg_state_o;
  logic [LANE_W-1:0]              dbg_lane_o;

  load_store_unit #(.THREADS(THREADS), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iaddr(iaddr), .instReq(instReq), .iload(iload), .iHit(iHit),
    .readReq(readReq), .writeReq(writeReq), .isVector(isVector),
    .sdaddr(sdaddr), .sdstore(sdstore), .sdload(sdload),
    .vdaddr(vdaddr), .vdstore(vdstore), .vdload(vdload),
    .dHit(dHit), .dhalt(dhalt),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_store(mem_store), .mem_load(mem_load), .mem_wait(mem_wait),
    .dbg_state_o(dbg_state_o), .dbg_lane_o(dbg_lane_o)
  );

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  logic [REC_W-1:0]  exp_q[$];            // expected memory accesses, in order
  int                wait_q[$];           // directed wait counts per access
  logic [WORD_W-1:0] mem [0:1023];        // word memory, addr[11:2]
  logic [WORD_W-1:0] m_sdload;
  logic [WORD_W-1:0] m_vdload [THREADS];

  int               ncyc;
  int               total_waits;
  int               waits_left;
  bit               in_access;
  bit               holding;
  logic [REC_W-1:0] held_rec;

  task automatic chk(input string tag, input logic [REC_W-1:0] obs,
                     input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: runs at the negedge, after the DUT outputs settled.
  // Decides mem_wait / mem_load for the current cycle and logs completed
  // accesses against the expected queue.
  task automatic mem_respond();
    logic [REC_W-1:0] rec;
    if (mem_ren || mem_wen) begin
      chk("strobe_exclusive", {mem_ren, mem_wen} == 2'b11, 1'b0);
      rec = {mem_ren, mem_wen, mem_addr, (mem_wen ? mem_store : '0)};
      if (holding) chk("hold_during_wait", rec, held_rec);
      if (!in_access) begin
        in_access  = 1;
        waits_left = (wait_q.size() > 0) ? wait_q.pop_front() : $urandom_range(0, 2);
      end
      if (waits_left > 0) begin
        mem_wait = 1'b1;
        mem_load = $urandom;
        waits_left--;
        total_waits++;
        holding  = 1;
        held_rec = rec;
      end else begin
        mem_wait  = 1'b0;
        mem_load  = mem_ren ? mem[mem_addr[11:2]] : $urandom;
        if (mem_wen) mem[mem_addr[11:2]] = mem_store;
        in_access = 0;
        holding   = 0;
        if (exp_q.size() == 0) chk("unexpected_access", rec, '0);
        else                   chk("access", rec, exp_q.pop_front());
      end
    end else begin
      if (holding) chk("hold_during_wait", '0, held_rec);
      mem_wait  = 1'b0;
      mem_load  = $urandom;
      holding   = 0;
      in_access = 0;
    end
  endtask

  // Runs one instruction from IDLE (or straight after a DONE with instReq
  // held). The expected access list, completion cycle and result registers
  // come from the instruction-level rules: fetch, then one access for a
  // scalar data phase or THREADS lane accesses in ascending order for a
  // vector one; latency 3 + data accesses + wait cycles.
  task automatic run_instr(input logic [WORD_W-1:0] instr, input logic rd,
                           input logic wr, input bit keep_req,
                           input int halt_cyc, input int rst_cyc,
                           output bit aborted);
    bit                is_vec;
    bit                has_data;
    bit                seen_hit;
    int                exp_lat;
    logic [WORD_W-1:0] exp_sd;
    logic [WORD_W-1:0] exp_vd [THREADS];

    mem[iaddr[11:2]] = instr;
    is_vec   = (instr[31:26] >= 6'h30);
    has_data = rd || wr;
    exp_q.delete();
    exp_q.push_back({2'b10, iaddr, 32'h0});
    exp_sd = m_sdload;
    for (int l = 0; l < THREADS; l++) exp_vd[l] = m_vdload[l];
    if (has_data && !is_vec) begin
      if (rd) begin
        exp_q.push_back({2'b10, sdaddr, 32'h0});
        exp_sd = mem[sdaddr[11:2]];
      end else begin
        exp_q.push_back({2'b01, sdaddr, sdstore});
      end
    end else if (has_data) begin
      for (int l = 0; l < THREADS; l++) begin
        if (rd) begin
          exp_q.push_back({2'b10, vdaddr[l], 32'h0});
          exp_vd[l] = mem[vdaddr[l][11:2]];
        end else begin
          exp_q.push_back({2'b01, vdaddr[l], vdstore[l]});
        end
      end
    end

    readReq     = rd;
    writeReq    = wr;
    instReq     = 1'b1;
    total_waits = 0;
    ncyc        = 0;
    seen_hit    = 0;
    aborted     = 0;
    while (!seen_hit && ncyc < 40) begin
      @(posedge CLK);
      @(negedge CLK);
      ncyc++;
      if (ncyc == rst_cyc) begin
        aborted = 1;
        return;
      end
      if (ncyc == halt_cyc) dhalt = 1'b1;
      if (iHit) begin
        seen_hit = 1;
        exp_lat  = 3 + (has_data ? (is_vec ? THREADS : 1) : 0) + total_waits;
        chk("ihit_cycle", ncyc, exp_lat);
        chk("dhit", dHit, has_data);
        chk("iload", iload, instr);
        chk("isvector", isVector, is_vec);
        chk("sdload", sdload, exp_sd);
        for (int l = 0; l < THREADS; l++) chk("vdload", vdload[l], exp_vd[l]);
        chk("accesses_left", exp_q.size(), 0);
        if (!keep_req) instReq = 1'b0;
      end else begin
        chk("dhit_without_ihit", dHit, 1'b0);
      end
      mem_respond();
    end
    if (!seen_hit) chk("ihit_timeout", 1'b0, 1'b1);
    m_sdload = exp_sd;
    for (int l = 0; l < THREADS; l++) m_vdload[l] = exp_vd[l];
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit               ab;
    int               kind;
    logic [WORD_W-1:0] instr;
    logic [1:0]       top;

    nRST     = 1'b0;
    iaddr    = '0;
    instReq  = 1'b0;
    readReq  = 1'b0;
    writeReq = 1'b0;
    sdaddr   = '0;
    sdstore  = '0;
    vdaddr   = '0;
    vdstore  = '0;
    dhalt    = 1'b0;
    mem_load = '0;
    mem_wait = 1'b0;
    m_sdload = '0;
    for (int l = 0; l < THREADS; l++) m_vdload[l] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    in_access = 0;
    holding   = 0;

    #1;
    chk("rst_iload", iload, 0);
    chk("rst_sdload", sdload, 0);
    chk("rst_vdload", vdload, 0);
    chk("rst_hits", {iHit, dHit}, 2'b00);
    chk("rst_strobes", {mem_ren, mem_wen}, 2'b00);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_lane", dbg_lane_o, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("idle_no_strobe", {mem_ren, mem_wen}, 2'b00);

    // Non-memory instruction at address 0.
    iaddr = 32'h0;
    wait_q = '{0};
    run_instr(32'h0022_1820, 1'b0, 1'b0, 0, 0, 0, ab);

    // Scalar load with two wait cycles on the data access.
    iaddr  = 32'h4;
    sdaddr = 32'h100;
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    wait_q = '{0, 2};
    run_instr(32'h8C00_0000, 1'b1, 1'b0, 0, 0, 0, ab);
    chk("sload_value", sdload, 32'hDEAD_BEEF);

    // Scalar store.
    iaddr   = 32'h8;
    sdaddr  = 32'h200;
    sdstore = 32'h1234_5678;
    wait_q  = '{0, 0};
    run_instr(32'hAC00_0000, 1'b0, 1'b1, 0, 0, 0, ab);

    // Vector load, four lanes.
    iaddr = 32'hC;
    for (int l = 0; l < THREADS; l++) begin
      vdaddr[l] = 32'h300 + 32'(4 * l);
      mem[(32'h300 >> 2) + l] = 32'(l + 1);
    end
    wait_q = '{0, 0, 0, 0, 0};
    run_instr(32'hC000_0000, 1'b1, 1'b0, 0, 0, 0, ab);
    for (int l = 0; l < THREADS; l++) chk("vload_value", vdload[l], 32'(l + 1));

    // Both requests high: read only.
    iaddr  = 32'h10;
    sdaddr = 32'h240;
    wait_q = '{1, 1};
    run_instr(32'h1000_0000, 1'b1, 1'b1, 0, 0, 0, ab);

    // Halt raised during the scalar data phase, instReq kept high.
    iaddr  = 32'h14;
    sdaddr = 32'h280;
    wait_q = '{0, 2};
    run_instr(32'h8C00_0004, 1'b1, 1'b0, 1, 3, 0, ab);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("parked_strobes", {mem_ren, mem_wen}, 2'b00);
      chk("parked_ihit", iHit, 1'b0);
    end
    instReq = 1'b0;
    dhalt   = 1'b0;
    @(negedge CLK);

    // Reset while the vector store is on lane 2.
    iaddr = 32'h18;
    for (int l = 0; l < THREADS; l++) begin
      vdaddr[l]  = 32'h400 + 32'(4 * l);
      vdstore[l] = $urandom;
    end
    wait_q = '{0, 0, 0};
    run_instr(32'hE400_0000, 1'b0, 1'b1, 0, 0, 5, ab);
    chk("reset_test_reached", ab, 1'b1);
    chk("pre_reset_lane", dbg_lane_o, 2'd2);
    chk("pre_reset_access", {mem_wen, mem_addr}, {1'b1, vdaddr[2]});
    nRST = 1'b0;
    #1;
    chk("arst_iload", iload, 0);
    chk("arst_sdload", sdload, 0);
    chk("arst_vdload", vdload, 0);
    chk("arst_hits", {iHit, dHit}, 2'b00);
    chk("arst_strobes", {mem_ren, mem_wen}, 2'b00);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_store", mem_store, 0);
    chk("arst_lane", dbg_lane_o, 0);
    m_sdload = '0;
    for (int l = 0; l < THREADS; l++) m_vdload[l] = '0;
    wait_q.delete();
    exp_q.delete();
    in_access = 0;
    holding   = 0;
    mem_wait  = 1'b0;
    writeReq  = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("refetch_ren", {mem_ren, mem_wen}, 2'b10);
    chk("refetch_addr", mem_addr, iaddr);
    mem_load = mem[iaddr[11:2]];
    instReq  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("no_stale_write", mem_wen, 1'b0);
      mem_load = $urandom;
    end

    // Random instructions.
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 5);
      top   = 2'($urandom_range(0, 2));
      if (kind == 3 || kind == 4 || (kind != 1 && kind != 2 && $urandom_range(0, 1) == 1))
        top = 2'b11;
      instr = {top, 30'($urandom)};
      iaddr   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      sdaddr  = {20'h0, 10'($urandom_range(64, 1023)), 2'b00};
      sdstore = $urandom;
      for (int l = 0; l < THREADS; l++) begin
        vdaddr[l]  = {20'h0, 10'($urandom_range(64, 1023)), 2'b00};
        vdstore[l] = $urandom;
      end
      run_instr(instr, (kind == 1 || kind == 3 || kind == 5),
                (kind == 2 || kind == 4 || kind == 5),
                bit'($urandom_range(0, 1)), 0, 0, ab);
    end
    instReq = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("final_idle", {mem_ren, mem_wen, iHit}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
